// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter
// Description : Latches rising edges on N lines as pending events and delivers
//               them one per transfer over valid/ready in round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    sig,
    input  logic [N-1:0]    en,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    input  logic            out_ready,
    output logic [N-1:0]    ovf,
    input  logic            ovf_clr
);

    localparam logic [ID_W-1:0] C_PTR_RST = ID_W'(N - 1);

    logic [N-1:0]    r_sig_dly;
    logic [N-1:0]    r_pending;
    logic [N-1:0]    r_ovf;
    logic            r_out_valid;
    logic [ID_W-1:0] r_out_id;
    logic [ID_W-1:0] r_rr_ptr;

    logic [N-1:0]    w_edge;
    logic            w_load;
    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic [N-1:0]    w_load_mask;
    logic [N-1:0]    w_drop;
    logic [N-1:0]    w_pending_nxt;
    logic [N-1:0]    w_ovf_nxt;

    // Returns {found, index}: first set bit of pend starting just after ptr.
    function automatic logic [ID_W:0] rr_pick(input logic [N-1:0]    pend,
                                              input logic [ID_W-1:0] ptr);
        logic            found;
        logic [ID_W-1:0] win;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (!found && pend[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    assign w_edge = sig & ~r_sig_dly & en;
    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_load_mask = '0;
        {w_found, w_win} = rr_pick(r_pending, r_rr_ptr);
        if (w_load && w_found) begin
            w_load_mask[w_win] = 1'b1;
        end
    end

    // A fresh edge on the line being loaded re-arms pending instead of dropping.
    assign w_drop        = w_edge & r_pending & ~w_load_mask;
    assign w_pending_nxt = (r_pending & ~w_load_mask) | w_edge;
    assign w_ovf_nxt     = (ovf_clr ? '0 : r_ovf) | w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_dly   <= '1;
            r_pending   <= '0;
            r_ovf       <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_rr_ptr    <= C_PTR_RST;
        end else begin
            r_sig_dly <= sig;
            r_pending <= w_pending_nxt;
            r_ovf     <= w_ovf_nxt;
            if (w_load) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_id <= w_win;
                    r_rr_ptr <= w_win;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_event_arbiter
// Description : Directed self-checking bench for edge_event_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    sig;
    logic [N-1:0]    en;
    logic            out_valid;
    logic [ID_W-1:0] out_id;
    logic            out_ready;
    logic [N-1:0]    ovf;
    logic            ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    logic [ID_W-1:0] got[$];

    edge_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .en        (en),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_ready (out_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sig = '0; en = '1; out_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Records every transfer seen over ncyc cycles into got.
    task automatic collect(input int ncyc);
        got.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (out_valid && out_ready) got.push_back(out_id);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sig = 4'b0001; en = '1; out_ready = 1'b1; ovf_clr = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_id !== 2'd0) begin n_err++; $display("FAIL rst_id got=%0d exp=0", out_id); end
        n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL rst_ovf got=%b exp=0000", ovf); end
        rst = 1'b0;
        collect(10);
        n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL rst_held_high transfers got=%0d exp=0", got.size()); end
        n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL rst_ovf_after got=%b exp=0000", ovf); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        sig = 4'b0100;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_lat1 valid got=%b exp=0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_lat2 valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_id !== 2'd2) begin n_err++; $display("FAIL single_id got=%0d exp=2", out_id); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_one_cycle valid got=%b exp=0", out_valid); end
        sig = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [ID_W-1:0] exp3[3] = '{2'd0, 2'd1, 2'd3};
        logic [ID_W-1:0] exp4[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        do_reset();
        out_ready = 1'b1;
        sig = 4'b1011;
        tick(); tick();
        collect(3);
        n_cmp++; if (got.size() !== 3) begin n_err++; $display("FAIL b2b_3_count got=%0d exp=3", got.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got[i] !== exp3[i]) begin n_err++; $display("FAIL b2b_3_order[%0d] got=%0d exp=%0d", i, got[i], exp3[i]); end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_3_drain valid got=%b exp=0", out_valid); end
        sig = 4'b0000; tick();
        sig = 4'b1111; tick(); tick();
        collect(4);
        n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL b2b_4_count got=%0d exp=4", got.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_cmp++; if (got[i] !== exp4[i]) begin n_err++; $display("FAIL b2b_4_order[%0d] got=%0d exp=%0d", i, got[i], exp4[i]); end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_4_drain valid got=%b exp=0", out_valid); end
        sig = 4'b0000; tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        sig = 4'b0110;
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin
                n_err++; $display("FAIL hold_stable[%0d] valid/id got=%b/%0d exp=1/1", c, out_valid, out_id);
            end
            tick();
        end
        out_ready = 1'b1;
        collect(4);
        n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL hold_count got=%0d exp=2", got.size()); end
        else begin
            n_cmp++; if (got[0] !== 2'd1) begin n_err++; $display("FAIL hold_first got=%0d exp=1", got[0]); end
            n_cmp++; if (got[1] !== 2'd2) begin n_err++; $display("FAIL hold_second got=%0d exp=2", got[1]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        sig = 4'b0001; tick(); tick();
        sig = 4'b1001; tick();
        sig = 4'b0001; tick();
        n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL ovf_first_edge got=%b exp=0000", ovf); end
        sig = 4'b1001; tick();
        n_cmp++; if (ovf !== 4'b1000) begin n_err++; $display("FAIL ovf_set got=%b exp=1000", ovf); end
        sig = 4'b0001;
        out_ready = 1'b1;
        collect(5);
        n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL ovf_count got=%0d exp=2", got.size()); end
        else begin
            n_cmp++; if (got[0] !== 2'd0) begin n_err++; $display("FAIL ovf_first got=%0d exp=0", got[0]); end
            n_cmp++; if (got[1] !== 2'd3) begin n_err++; $display("FAIL ovf_only_one_3 got=%0d exp=3", got[1]); end
        end
        n_cmp++; if (ovf !== 4'b1000) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1000", ovf); end
        ovf_clr = 1'b1; tick();
        ovf_clr = 1'b0;
        n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL ovf_clear got=%b exp=0000", ovf); end
    endtask

    task automatic test_edge_on_load();
        do_reset();
        sig = 4'b0001; tick(); tick();
        sig = 4'b0101; tick();
        sig = 4'b0001; tick();
        sig = 4'b0101; out_ready = 1'b1;
        collect(4);
        n_cmp++; if (got.size() !== 3) begin n_err++; $display("FAIL reload_count got=%0d exp=3", got.size()); end
        else begin
            n_cmp++; if (got[0] !== 2'd0) begin n_err++; $display("FAIL reload_0 got=%0d exp=0", got[0]); end
            n_cmp++; if (got[1] !== 2'd2 || got[2] !== 2'd2) begin
                n_err++; $display("FAIL reload_22 got=%0d,%0d exp=2,2", got[1], got[2]);
            end
        end
        n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL reload_no_ovf got=%b exp=0000", ovf); end
    endtask

    task automatic test_enable();
        do_reset();
        sig = 4'b0001; tick(); tick();
        sig = 4'b0101; tick();
        en = 4'b0000; out_ready = 1'b1;
        collect(4);
        n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL en_keep_count got=%0d exp=2", got.size()); end
        else begin
            n_cmp++; if (got[1] !== 2'd2) begin n_err++; $display("FAIL en_keep_pending got=%0d exp=2", got[1]); end
        end
        do_reset();
        en = 4'b1110; out_ready = 1'b1;
        sig = 4'b0001;
        collect(5);
        n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL en_masked transfers got=%0d exp=0", got.size()); end
        en = '1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        sig = 4'b0110; tick(); tick();
        sig = 4'b0010; tick();
        sig = 4'b0110; tick();
        n_cmp++; if (ovf !== 4'b0100) begin n_err++; $display("FAIL mid_ovf_pre got=%b exp=0100", ovf); end
        rst = 1'b1; tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ovf got=%b exp=0000", ovf); end
        rst = 1'b0; out_ready = 1'b1;
        collect(10);
        n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL mid_rst_dropped transfers got=%0d exp=0", got.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_edge_on_load();
        test_enable();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
